psum_drain_requant: RTL and testbench

Downstream of the PE column. Captures NUM_PE signed partial sums in parallel, once the column has finished MAC/bias/ReLU.
Drains them one per beat over a valid/ready stream. Each value is requantized: arithmetic right shift by FRAC_SHIFT, then saturation to OUT_WIDTH signed.
Feeds the ofmap buffer writer and reports per-beat saturation.

---
 rtl/pe_pkg.sv | 25 ++
 rtl/requant_sat.sv | 51 +++++
 rtl/psum_drain_requant.sv | 126 ++++++++++++
 tb/tb_psum_drain_requant.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and types for the PE column and its output path.
//   IFMAP_WIDTH/WEIGHT_WIDTH : operand widths of the MAC array
//   ACC_WIDTH/PSUM_WIDTH     : signed accumulator width (8+8+3 guard bits)
//   OUT_WIDTH                : signed output activation width
//   FRAC_SHIFT               : requant right shift (bias alignment scale 2^7)
//   psum_t, act_t            : signed psum / activation types
//   drain_state_e            : psum drain FSM states
package pe_pkg;

    localparam int IFMAP_WIDTH  = 8;
    localparam int WEIGHT_WIDTH = 8;
    localparam int ACC_WIDTH    = IFMAP_WIDTH + WEIGHT_WIDTH + 3;
    localparam int PSUM_WIDTH   = ACC_WIDTH;
    localparam int OUT_WIDTH    = 8;
    localparam int FRAC_SHIFT   = 7;

    typedef logic signed [PSUM_WIDTH-1:0] psum_t;
    typedef logic signed [OUT_WIDTH-1:0]  act_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational requantizer, signed psum -> signed activation.
//   i_psum : signed psum (PSUM_W bits)
//   o_act  : psum >>> SHIFT, saturated to OUT_W signed
//   o_sat  : high when the result was clipped
// Build option: PSUM_ROUND_EN adds 2^(SHIFT-1) before the shift
// (round-half-up); otherwise the shift truncates toward -inf.
// Saturation is applied after rounding in both builds.
import pe_pkg::*;

module requant_sat #(
    parameter int PSUM_W = pe_pkg::PSUM_WIDTH,
    parameter int OUT_W  = pe_pkg::OUT_WIDTH,
    parameter int SHIFT  = pe_pkg::FRAC_SHIFT
) (
    input  logic signed [PSUM_W-1:0] i_psum,
    output logic signed [OUT_W-1:0]  o_act,
    output logic                     o_sat
);

    // One extra bit so the rounding add cannot wrap at the max psum.
    localparam int EW = PSUM_W + 1;
    localparam logic signed [EW-1:0] C_MAX = EW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] C_MIN = ~C_MAX;

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_rnd;
    logic signed [EW-1:0] w_t;

    assign w_ext = {i_psum[PSUM_W-1], i_psum};

`ifdef PSUM_ROUND_EN
    assign w_rnd = w_ext + EW'(2 ** (SHIFT - 1));
`else
    assign w_rnd = w_ext;
`endif

    assign w_t = w_rnd >>> SHIFT;

    always_comb begin
        o_act = w_t[OUT_W-1:0];
        o_sat = 1'b0;
        if (w_t > C_MAX) begin
            o_act = C_MAX[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_t < C_MIN) begin
            o_act = C_MIN[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/psum_drain_requant.sv
// psum_drain_requant: captures NUM_PE psums in one cycle and drains them one
// per beat, requantized, over a valid/ready stream to the ofmap writer.
//   clk, nrst     : clock, asynchronous active-low reset
//   en            : synchronous enable; low clears FSM, index and buffer
//   load_i        : capture request, accepted when load_ready_o
//   psum_i        : packed psums, element k at [k*PSUM_WIDTH +: PSUM_WIDTH]
//   load_ready_o  : idle and enabled
//   out_valid_o   : beat valid (DRAIN state)
//   out_ready_i   : consumer accepts beat
//   out_data_o    : requantized value of buf[idx]
//   out_idx_o     : PE index of the current beat
//   out_last_o    : current index is NUM_PE-1
//   out_sat_o     : current beat was clipped
// Build option: PSUM_ROUND_EN selects round-half-up requant (see requant_sat).
import pe_pkg::*;

module psum_drain_requant #(
    parameter int NUM_PE     = 8,
    parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH,
    parameter int OUT_WIDTH  = pe_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT = pe_pkg::FRAC_SHIFT,
    parameter int IDX_WIDTH  = $clog2(NUM_PE)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         load_i,
    input  logic [NUM_PE*PSUM_WIDTH-1:0] psum_i,
    output logic                         load_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_WIDTH-1:0]         out_data_o,
    output logic [IDX_WIDTH-1:0]         out_idx_o,
    output logic                         out_last_o,
    output logic                         out_sat_o
);

    localparam logic [IDX_WIDTH-1:0] C_LAST = IDX_WIDTH'(NUM_PE - 1);

    drain_state_e r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [NUM_PE-1:0][PSUM_WIDTH-1:0] r_buf;
    logic w_accept;

    logic signed [PSUM_WIDTH-1:0] w_sel;
    logic signed [OUT_WIDTH-1:0]  w_act;
    logic                         w_sat;

    // Next-state logic; en low forces the synchronous clear.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = DRAIN;
                        w_idx_nxt   = '0;
                    end
                end
                DRAIN: begin
                    // load_i is deliberately ignored here.
                    if (out_ready_i) begin
                        if (r_idx == C_LAST) begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Packed layout of r_buf matches psum_i, so capture is a plain copy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_buf <= '0;
        end else if (!en) begin
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= psum_i;
        end
    end

    // Output datapath depends only on registers, so it holds under stall.
    assign w_sel = r_buf[r_idx];

    requant_sat #(
        .PSUM_W (PSUM_WIDTH),
        .OUT_W  (OUT_WIDTH),
        .SHIFT  (FRAC_SHIFT)
    ) u_requant (
        .i_psum (w_sel),
        .o_act  (w_act),
        .o_sat  (w_sat)
    );

    assign load_ready_o = en & (r_state == IDLE);
    assign out_valid_o  = (r_state == DRAIN);
    assign out_data_o   = w_act;
    assign out_sat_o    = w_sat;
    assign out_idx_o    = r_idx;
    assign out_last_o   = (r_idx == C_LAST);

endmodule

// File: tb/tb_psum_drain_requant.sv
// tb_psum_drain_requant: directed bench for psum_drain_requant with
// hand-computed expectations for both the truncating and PSUM_ROUND_EN builds.
module tb_psum_drain_requant;

    localparam int NPE = 8;
    localparam int PW  = 19;
    localparam int OW  = 8;
    localparam int IW  = 3;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              load_i;
    logic [NPE*PW-1:0] psum_i;
    logic              load_ready_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OW-1:0]     out_data_o;
    logic [IW-1:0]     out_idx_o;
    logic              out_last_o;
    logic              out_sat_o;

    psum_drain_requant #(
        .NUM_PE     (NPE),
        .PSUM_WIDTH (PW),
        .OUT_WIDTH  (OW),
        .FRAC_SHIFT (7),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .load_i       (load_i),
        .psum_i       (psum_i),
        .load_ready_o (load_ready_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_idx_o    (out_idx_o),
        .out_last_o   (out_last_o),
        .out_sat_o    (out_sat_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int vals  [NPE];
    int exp_d [NPE];
    int exp_s [NPE];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents vals[] on psum_i and pulses load_i for one cycle; returns at
    // the negedge after the accepting edge, where beat 0 is already visible.
    task automatic do_load();
        @(negedge clk);
        chk("ld_ready", int'(load_ready_o), 1);
        for (int k = 0; k < NPE; k++) psum_i[k*PW +: PW] = PW'(vals[k]);
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    // Drains all beats with out_ready_i held high.
    task automatic drain_all(input string pfx);
        for (int k = 0; k < NPE; k++) begin
            chk($sformatf("%s_valid%0d", pfx, k), int'(out_valid_o), 1);
            chk($sformatf("%s_idx%0d", pfx, k), int'(out_idx_o), k);
            chk($sformatf("%s_data%0d", pfx, k), int'($signed(out_data_o)), exp_d[k]);
            chk($sformatf("%s_sat%0d", pfx, k), int'(out_sat_o), exp_s[k]);
            chk($sformatf("%s_last%0d", pfx, k), int'(out_last_o), (k == NPE-1) ? 1 : 0);
            @(negedge clk);
        end
        chk($sformatf("%s_end_valid", pfx), int'(out_valid_o), 0);
        chk($sformatf("%s_end_ready", pfx), int'(load_ready_o), 1);
    endtask

    initial begin
        int got;
        bit rdy;

        nrst = 1'b0; en = 1'b1; load_i = 1'b0; out_ready_i = 1'b1; psum_i = '0;
        #12;
        chk("rst_valid", int'(out_valid_o), 0);
        chk("rst_ready", int'(load_ready_o), 1);
        chk("rst_data", int'($signed(out_data_o)), 0);
        chk("rst_sat", int'(out_sat_o), 0);
        chk("rst_last", int'(out_last_o), 0);
        chk("rst_idx", int'(out_idx_o), 0);
        @(negedge clk);
        nrst = 1'b1;

        // Ramp 0..7 scaled by 2^7, consumer always ready.
        for (int k = 0; k < NPE; k++) begin
            vals[k] = k << 7; exp_d[k] = k; exp_s[k] = 0;
        end
        do_load();
        drain_all("ramp");

        // Saturation and rounding corners.
        vals = '{16384, -20000, 16256, 200, -1, 192, -129, 262143};
`ifdef PSUM_ROUND_EN
        exp_d = '{127, -128, 127, 2, 0, 2, -1, 127};
`else
        exp_d = '{127, -128, 127, 1, -1, 1, -2, 127};
`endif
        exp_s = '{1, 1, 0, 0, 0, 0, 0, 1};
        do_load();
        drain_all("sat");

        // Random backpressure with load_i pulses during DRAIN.
        for (int k = 0; k < NPE; k++) vals[k] = (10 + k) << 7;
        out_ready_i = 1'b0;
        do_load();
        got = 0;
        for (int cyc = 0; cyc < 200 && got < NPE; cyc++) begin
            chk("bp_valid", int'(out_valid_o), 1);
            chk("bp_idx", int'(out_idx_o), got);
            chk("bp_data", int'($signed(out_data_o)), 10 + got);
            chk("bp_last", int'(out_last_o), (got == NPE-1) ? 1 : 0);
            rdy = 1'($urandom_range(0, 1));
            out_ready_i = rdy;
            load_i = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (rdy) got++;
        end
        load_i = 1'b0;
        out_ready_i = 1'b1;
        chk("bp_count", got, NPE);
        chk("bp_end_valid", int'(out_valid_o), 0);
        chk("bp_end_ready", int'(load_ready_o), 1);
        @(negedge clk);
        chk("bp_noload", int'(out_valid_o), 0);

        // en dropped after beat 3 transfers.
        for (int k = 0; k < NPE; k++) vals[k] = (k + 1) << 7;
        do_load();
        for (int k = 0; k < 4; k++) begin
            chk("en_idx", int'(out_idx_o), k);
            chk("en_data", int'($signed(out_data_o)), k + 1);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("en_valid", int'(out_valid_o), 0);
        chk("en_ready_low", int'(load_ready_o), 0);
        chk("en_idx0", int'(out_idx_o), 0);
        chk("en_last", int'(out_last_o), 0);
        en = 1'b1;
        #1;
        chk("en_ready_back", int'(load_ready_o), 1);
        chk("en_buf_clr", int'($signed(out_data_o)), 0);
        @(negedge clk);
        chk("en_stay_idle", int'(out_valid_o), 0);

        // Asynchronous reset mid-drain.
        do_load();
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid_o), 0);
        chk("arst_idx", int'(out_idx_o), 0);
        chk("arst_data", int'($signed(out_data_o)), 0);
        chk("arst_ready", int'(load_ready_o), 1);
        @(negedge clk);
        nrst = 1'b1;

        // Recovery after reset.
        for (int k = 0; k < NPE; k++) begin
            vals[k] = k << 7; exp_d[k] = k; exp_s[k] = 0;
        end
        do_load();
        drain_all("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
